// File: rtl/frame_stream_pkg.sv
// Shared types for the frame stream source.
//   state_e      : source FSM states (idle, reading, draining)
//   stream_tag_t : per-read tag carried alongside the memory data
//   pix_count()  : pixels per frame
package frame_stream_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StFlush = 2'd2
   } state_e;

   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } stream_tag_t;

   function automatic int unsigned pix_count(input int unsigned w, input int unsigned h);
      return w * h;
   endfunction

endpackage

// File: rtl/frame_stream_pipe.sv
// Two-stage tag/data pipeline aligning read tags with 1-cycle-latency memory data.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   tag       : tag of the read issued this cycle
//   rd_data   : memory data (belongs to the read issued one cycle earlier)
//   pix_data  : registered pixel, holds its value during bubbles
//   pix_valid : pixel qualifier
//   sof, eof  : first/last pixel markers, only ever high with pix_valid
module frame_stream_pipe
   import frame_stream_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  stream_tag_t       tag,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   output logic              sof,
   output logic              eof
);

   stream_tag_t tag_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_q     <= '0;
         pix_data  <= '0;
         pix_valid <= 1'b0;
         sof       <= 1'b0;
         eof       <= 1'b0;
      end else begin
         tag_q     <= tag;
         pix_valid <= tag_q.valid;
         sof       <= tag_q.valid & tag_q.first;
         eof       <= tag_q.valid & tag_q.last;
         if (tag_q.valid) begin
            pix_data <= rd_data;
         end
      end
   end

endmodule

// File: rtl/frame_stream_source.sv
// Frame stream source: reads an IMG_W x IMG_H frame in raster order from a
// synchronous-read memory and emits it as a pix_valid/sof/eof pixel stream.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : begin a frame (sampled only when idle)
//   pause       : suppress new memory reads while high (creates bubbles)
//   mem_rd_en   : memory read strobe
//   mem_addr    : linear pixel address
//   mem_rd_data : memory data, valid one cycle after mem_rd_en
//   pix_data    : pixel output
//   pix_valid   : pixel qualifier
//   sof, eof    : first / last pixel of the frame
//   busy        : frame in progress (includes the eof cycle)
//   done        : one-cycle pulse coincident with eof
//   frame_cnt   : (FRAME_STREAM_CONTINUOUS_EN only) 16-bit wrapping eof count
// Build option FRAME_STREAM_CONTINUOUS_EN: holding start on the last read of a
// frame restarts at address 0 without draining, giving back-to-back frames.
module frame_stream_source
   import frame_stream_pkg::*;
#(
   parameter int unsigned IMG_W  = 6,
   parameter int unsigned IMG_H  = 6,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pause,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   output logic              sof,
   output logic              eof,
   output logic              busy,
   output logic              done
`ifdef FRAME_STREAM_CONTINUOUS_EN
   ,
   output logic [15:0]       frame_cnt
`endif
);

   localparam int unsigned       NPIX      = pix_count(IMG_W, IMG_H);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

   if ((NPIX == 0) || (longint'(NPIX) > (longint'(1) << ADDR_W))) begin : g_bad_geometry
      $error("frame_stream_source: IMG_W*IMG_H must be in 1..2**ADDR_W");
   end

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic              rd_en;
   logic              at_last;
   stream_tag_t       issue_tag;

   assign rd_en   = (state_q == StRun) && !pause;
   assign at_last = (addr_q == LAST_ADDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StRun;
                  addr_q  <= '0;
               end
            end
            StRun: begin
               if (rd_en) begin
                  if (at_last) begin
`ifdef FRAME_STREAM_CONTINUOUS_EN
                     if (start) begin
                        addr_q <= '0;
                     end else begin
                        state_q <= StFlush;
                     end
`else
                     state_q <= StFlush;
`endif
                  end else begin
                     addr_q <= addr_q + 1'b1;
                  end
               end
            end
            StFlush: begin
               // Reads already issued drain regardless of pause; leave on eof.
               if (eof) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      issue_tag       = '0;
      issue_tag.valid = rd_en;
      issue_tag.first = (addr_q == '0);
      issue_tag.last  = at_last;
   end

   frame_stream_pipe #(
      .DATA_W (DATA_W)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .tag       (issue_tag),
      .rd_data   (mem_rd_data),
      .pix_data  (pix_data),
      .pix_valid (pix_valid),
      .sof       (sof),
      .eof       (eof)
   );

   assign mem_rd_en = rd_en;
   assign mem_addr  = addr_q;
   // Stay busy through the eof cycle even though the FSM is leaving FLUSH.
   assign busy      = (state_q != StIdle) || eof;
   assign done      = eof;

`ifdef FRAME_STREAM_CONTINUOUS_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_q <= '0;
      end else if (eof) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule
